// File: rtl/alu_bcd_seq.sv
// Sequential add/sub/mul/div ALU followed by serial double-dabble BCD conversion.
// Define ALU_BCD_REM_EN to expose the binary division remainder on port rem.
module alu_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      left,
    input  logic [WIDTH-1:0]      right,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  err
`ifdef ALU_BCD_REM_EN
    ,
    output logic [WIDTH-1:0]      rem
`endif
);

    localparam int RW = 2 * WIDTH;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(RW) + 1;

    typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t            state;
    state_t            state_nx;
    op_t               op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [WIDTH-1:0]  rem_w;
    logic [RW-1:0]     res;
    logic [BW-1:0]     bcd_w;
    logic [BW-1:0]     adj;
    logic [BW-1:0]     bcd_nx;
    logic [CW-1:0]     cnt;
    logic              neg_w;

    logic              div0;
    logic              calc_last;
    logic              conv_last;

    logic [WIDTH:0]    trial;
    logic              ge;
    logic [WIDTH-1:0]  rem_nx;
    logic [WIDTH-1:0]  q_nx;

    assign div0      = (mode == 2'd3) && (right == '0);
    assign calc_last = (op != OP_DIV) || (cnt == CW'(WIDTH - 1));
    assign conv_last = (cnt == CW'(RW - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Restoring division: the dividend register shifts out from the top
    // while quotient bits shift in at the bottom.
    assign trial  = {rem_w, a[WIDTH-1]};
    assign ge     = (trial >= {1'b0, b});
    assign rem_nx = ge ? (trial[WIDTH-1:0] - b) : trial[WIDTH-1:0];
    assign q_nx   = {a[WIDTH-2:0], ge};

    always_comb begin
        adj = bcd_w;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_w[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_w[4*i +: 4] + 4'd3;
        end
        bcd_nx = (adj << 1) | BW'(res[RW-1]);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = div0 ? DONE : CALC;
            CALC: if (calc_last) state_nx = CONV;
            CONV: if (conv_last) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op    <= OP_ADD;
            a     <= '0;
            b     <= '0;
            rem_w <= '0;
            res   <= '0;
            bcd_w <= '0;
            cnt   <= '0;
            neg_w <= 1'b0;
            bcd   <= '0;
            neg   <= 1'b0;
            err   <= 1'b0;
`ifdef ALU_BCD_REM_EN
            rem   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a     <= left;
                        b     <= right;
                        op    <= op_t'(mode);
                        cnt   <= '0;
                        rem_w <= '0;
                        res   <= '0;
                        bcd_w <= '0;
                        neg_w <= 1'b0;
                        if (div0) begin
                            bcd <= '0;
                            neg <= 1'b0;
                            err <= 1'b1;
`ifdef ALU_BCD_REM_EN
                            rem <= '0;
`endif
                        end
                    end
                end
                CALC: begin
                    unique case (op)
                        OP_ADD: res <= RW'(a) + RW'(b);
                        OP_SUB: begin
                            res   <= (a >= b) ? RW'(a - b) : RW'(b - a);
                            neg_w <= (a < b);
                        end
                        OP_MUL: res <= RW'(a) * RW'(b);
                        OP_DIV: begin
                            a     <= q_nx;
                            rem_w <= rem_nx;
                            if (calc_last)
                                res <= RW'(q_nx);
                        end
                        default: res <= '0;
                    endcase
                    cnt <= calc_last ? '0 : cnt + 1'b1;
                end
                CONV: begin
                    bcd_w <= bcd_nx;
                    res   <= res << 1;
                    cnt   <= cnt + 1'b1;
                    if (conv_last) begin
                        bcd <= bcd_nx;
                        neg <= neg_w;
                        err <= 1'b0;
`ifdef ALU_BCD_REM_EN
                        rem <= (op == OP_DIV) ? rem_w : '0;
`endif
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bcd_seq.sv
// Directed bench for alu_bcd_seq (WIDTH=8, DIGITS=5).
module tb_alu_bcd_seq;

    localparam int W = 8;
    localparam int D = 5;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   left  = '0;
    logic [W-1:0]   right = '0;
    logic [1:0]     mode  = '0;
    logic           busy;
    logic           done;
    logic [4*D-1:0] bcd;
    logic           neg;
    logic           err;
`ifdef ALU_BCD_REM_EN
    logic [W-1:0]   rem;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .left  (left),
        .right (right),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .neg   (neg),
        .err   (err)
`ifdef ALU_BCD_REM_EN
        ,
        .rem   (rem)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Issue one op from IDLE, count edges after accept until done.
    // poke >= 0 pulses start with junk operands at that cycle.
    task automatic run_op(input string tag, input logic [7:0] l,
                          input logic [7:0] r, input logic [1:0] m,
                          input int exp_lat, input logic [19:0] exp_bcd,
                          input logic exp_neg, input logic exp_err,
                          input logic [7:0] exp_rem, input int poke);
        int lat;
        left  = l;
        right = r;
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 60) begin
            if (lat == poke) begin
                start = 1'b1;
                left  = 8'd1;
                right = 8'd1;
                mode  = 2'd2;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_bcd"}, bcd, exp_bcd);
        chk({tag, "_neg"}, neg, exp_neg);
        chk({tag, "_err"}, err, exp_err);
`ifdef ALU_BCD_REM_EN
        chk({tag, "_rem"}, rem, exp_rem);
`endif
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        int lat;
        int seen;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_bcd", bcd, 20'h0);
        chk("rst_neg", neg, 1'b0);
        chk("rst_err", err, 1'b0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("add_7_5", 8'd7, 8'd5, 2'd0, 17, 20'h00012, 0, 0, 0, -1);
        run_op("sub_5_7", 8'd5, 8'd7, 2'd1, 17, 20'h00002, 1, 0, 0, -1);
        run_op("sub_7_5", 8'd7, 8'd5, 2'd1, 17, 20'h00002, 0, 0, 0, -1);
        run_op("mul_max", 8'd255, 8'd255, 2'd2, 17, 20'h65025, 0, 0, 0, -1);
        run_op("mul_zero", 8'd0, 8'd255, 2'd2, 17, 20'h00000, 0, 0, 0, -1);
        run_op("div_200_7", 8'd200, 8'd7, 2'd3, 24, 20'h00028, 0, 0, 8'd4, -1);
        // Divide by zero reaches DONE on the accept edge itself.
        run_op("div0", 8'd9, 8'd0, 2'd3, 0, 20'h00000, 0, 1, 0, -1);
        run_op("add_3_4", 8'd3, 8'd4, 2'd0, 17, 20'h00007, 0, 0, 0, -1);
        run_op("add_zero", 8'd0, 8'd0, 2'd0, 17, 20'h00000, 0, 0, 0, -1);
        run_op("poke", 8'd12, 8'd13, 2'd0, 17, 20'h00025, 0, 0, 0, 5);

        // Back-to-back with start held high.
        left  = 8'd2;
        right = 8'd3;
        mode  = 2'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_first_bcd", bcd, 20'h00005);
        left  = 8'd4;
        right = 8'd4;
        @(posedge clk);
        #1;
        chk("b2b_idle", busy, 1'b0);
        @(posedge clk);
        #1;
        chk("b2b_accept", busy, 1'b1);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_lat", lat, 17);
        chk("b2b_bcd", bcd, 20'h00008);
        @(posedge clk);
        #1;

        run_op("pre_rst", 8'd5, 8'd7, 2'd1, 17, 20'h00002, 1, 0, 0, -1);

        // Reset in the middle of conversion.
        left  = 8'd50;
        right = 8'd50;
        mode  = 2'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_bcd", bcd, 20'h0);
        chk("mrst_neg", neg, 1'b0);
        chk("mrst_err", err, 1'b0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("mrst_no_done", seen, 0);
        run_op("post_rst", 8'd99, 8'd99, 2'd2, 17, 20'h09801, 0, 0, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
